// File: rtl/i2c_master_arbiter_if.sv
// i2c_master_arbiter_if: requester-side and i2c_master-side signals of the round-robin arbiter
interface i2c_master_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req_i;
    logic [NUM_REQ-1:0]   req_rnw_i;
    logic [7*NUM_REQ-1:0] req_addr_i;
    logic [8*NUM_REQ-1:0] req_wdata_i;
    logic [NUM_REQ-1:0]   gnt_o;
    logic [NUM_REQ-1:0]   done_o;
    logic [NUM_REQ-1:0]   err_o;
    logic [7:0]           rdata_o;
    logic                 m_start_o;
    logic                 m_stop_o;
    logic                 m_read_nwrite_o;
    logic [6:0]           m_slave_addr_o;
    logic [7:0]           m_data_o;
    logic [7:0]           m_data_i;
    logic                 m_busy_i;
    logic                 m_error_i;
    logic                 m_success_i;
    logic                 arb_busy_o;

    modport master (
        input  req_i, req_rnw_i, req_addr_i, req_wdata_i,
        input  m_data_i, m_busy_i, m_error_i, m_success_i,
        output gnt_o, done_o, err_o, rdata_o, arb_busy_o,
        output m_start_o, m_stop_o, m_read_nwrite_o, m_slave_addr_o, m_data_o
    );

    modport slave (
        output req_i, req_rnw_i, req_addr_i, req_wdata_i,
        output m_data_i, m_busy_i, m_error_i, m_success_i,
        input  gnt_o, done_o, err_o, rdata_o, arb_busy_o,
        input  m_start_o, m_stop_o, m_read_nwrite_o, m_slave_addr_o, m_data_o
    );
endinterface

// File: rtl/i2c_master_arbiter.sv
// i2c_master_arbiter: round-robin sharing of one i2c_master between NUM_REQ one-byte requesters.
// Define I2C_ARB_TIMEOUT_EN to add the WAIT_DONE timeout counter and the ABORT (m_stop_o) state.
module i2c_master_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int START_HOLD_MAX = 1023
) (
    input logic                  clk,
    input logic                  rst_n,
    i2c_master_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int HW = $clog2(START_HOLD_MAX + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(START_HOLD_MAX - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_REQ - 1);

    typedef enum logic [2:0] {
        IDLE, LATCH, START, WAIT_DONE, RESP
`ifdef I2C_ARB_TIMEOUT_EN
        , ABORT
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [2:0]          sync1_q, sync2_q;
    logic                busy_s, error_s, success_s;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [IW-1:0]       idx_q, idx_d, ptr_q, ptr_d, sel_idx;
    logic                sel_found;
    int                  sel_j;
    logic                rnw_q, rnw_d;
    logic [6:0]          addr_q, addr_d;
    logic [7:0]          wdata_q, wdata_d, rdata_q, rdata_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic                err_seen_q, err_seen_d, fail_q, fail_d;

    assign {success_s, error_s, busy_s} = sync2_q;

    // Two-flop synchronisers for the master's slow-domain status lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {bus.m_success_i, bus.m_error_i, bus.m_busy_i};
            sync2_q <= sync1_q;
        end
    end

    // Round-robin pick: lowest offset from the pointer wins, so scan offsets downwards
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_j     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sel_j = int'(ptr_q) + i;
            if (sel_j >= NUM_REQ) sel_j = sel_j - NUM_REQ;
            if (bus.req_i[IW'(sel_j)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(sel_j);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            rnw_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            hold_q     <= '0;
            err_seen_q <= 1'b0;
            fail_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            rnw_q      <= rnw_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            hold_q     <= hold_d;
            err_seen_q <= err_seen_d;
            fail_q     <= fail_d;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] to_q, to_d;

    // Timeout counter: cleared before START, runs in WAIT_DONE and restarts for the ABORT window
    always_comb begin
        to_d = to_q;
        if (state_q == LATCH) to_d = '0;
        if (state_q == WAIT_DONE) to_d = (to_q == TO_LAST) ? '0 : to_q + 16'd1;
        if (state_q == ABORT) to_d = to_q + 16'd1;
    end

    // Timeout counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) to_q <= '0;
        else        to_q <= to_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      state_d = sel_found ? LATCH : IDLE;
            LATCH:     state_d = START;
            START:     state_d = busy_s ? WAIT_DONE : (hold_q == HOLD_LAST) ? RESP : START;
`ifdef I2C_ARB_TIMEOUT_EN
            WAIT_DONE: state_d = !busy_s ? RESP : (to_q == TO_LAST) ? ABORT : WAIT_DONE;
            ABORT:     state_d = (!busy_s || to_q == TO_LAST) ? RESP : ABORT;
`else
            WAIT_DONE: state_d = !busy_s ? RESP : WAIT_DONE;
`endif
            RESP:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Grant, request latching, result and pointer bookkeeping per state
    always_comb begin
        gnt_d      = gnt_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        rnw_d      = rnw_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        hold_d     = hold_q;
        err_seen_d = err_seen_q;
        fail_d     = fail_q;
        if (state_q == IDLE && sel_found) begin
            gnt_d          = '0;
            gnt_d[sel_idx] = 1'b1;
            idx_d          = sel_idx;
        end
        if (state_q == LATCH) begin
            rnw_d      = bus.req_rnw_i[idx_q];
            addr_d     = bus.req_addr_i[int'(idx_q) * 7 +: 7];
            wdata_d    = bus.req_wdata_i[int'(idx_q) * 8 +: 8];
            hold_d     = '0;
            err_seen_d = 1'b0;
            fail_d     = 1'b0;
        end
        if (state_q == START) begin
            hold_d = hold_q + HW'(1);
            fail_d = !busy_s && hold_q == HOLD_LAST;
        end
        if (state_q == WAIT_DONE) begin
            err_seen_d = err_seen_q | error_s;
            if (!busy_s) begin
                fail_d  = err_seen_q | error_s | !success_s;
                rdata_d = (success_s && !(err_seen_q | error_s) && rnw_q) ? bus.m_data_i : rdata_q;
            end
        end
`ifdef I2C_ARB_TIMEOUT_EN
        if (state_q == ABORT) fail_d = 1'b1;
`endif
        if (state_q == RESP) begin
            gnt_d = '0;
            ptr_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end
    end

    // Outputs decoded from the state and the registered datapath
    always_comb begin
        bus.gnt_o           = gnt_q;
        bus.done_o          = (state_q == RESP && !fail_q) ? gnt_q : '0;
        bus.err_o           = (state_q == RESP && fail_q) ? gnt_q : '0;
        bus.rdata_o         = rdata_q;
        bus.m_start_o       = state_q == START;
`ifdef I2C_ARB_TIMEOUT_EN
        bus.m_stop_o        = state_q == ABORT;
`else
        bus.m_stop_o        = 1'b0;
`endif
        bus.m_read_nwrite_o = rnw_q;
        bus.m_slave_addr_o  = addr_q;
        bus.m_data_o        = wdata_q;
        bus.arb_busy_o      = state_q != IDLE;
    end
endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb_i2c_master_arbiter: randomized bench with a behavioural i2c master and a round-robin scoreboard
`timescale 1ns/1ps
module tb_i2c_master_arbiter;
    localparam int N    = 4;
    localparam int HOLD = 100;
    localparam int TMO  = 300;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    i2c_master_arbiter_if #(.NUM_REQ(N)) bus ();
    i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO), .START_HOLD_MAX(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int fails = 0;
    int ptr_m = 0;
    logic [7:0] last_rd = '0;
    logic       r_rnw [N];
    logic [6:0] r_addr [N];
    logic [7:0] r_wd [N];
    int   m_dly = 0;
    int   m_len = 3;
    bit   m_nack = 0;
    bit   m_no_busy = 0;
    bit   m_stuck = 0;
    logic [7:0] m_rd = '0;

    function automatic int pick(input logic [N-1:0] m, input int p);
        for (int i = 0; i < N; i++) if (m[(p + i) % N]) return (p + i) % N;
        return 0;
    endfunction

    task automatic set_req(input int k, input logic rnw, input logic [6:0] a, input logic [7:0] d);
        r_rnw[k] = rnw;
        r_addr[k] = a;
        r_wd[k] = d;
        bus.req_rnw_i[k] = rnw;
        bus.req_addr_i[k*7 +: 7] = a;
        bus.req_wdata_i[k*8 +: 8] = d;
    endtask

    task automatic master_model();
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                bus.m_busy_i = 1'b0;
                bus.m_success_i = 1'b0;
                bus.m_error_i = 1'b0;
            end else if (bus.m_start_o && !m_no_busy) begin
                bus.m_success_i = 1'b0;
                bus.m_error_i = 1'b0;
                for (int i = 0; i < m_dly && rst_n; i++) @(negedge clk);
                bus.m_busy_i = rst_n;
                for (int i = 0; (i < m_len || m_stuck) && rst_n && !bus.m_stop_o; i++) @(negedge clk);
                bus.m_busy_i = 1'b0;
                if (rst_n) begin
                    bus.m_success_i = !m_nack;
                    bus.m_error_i = m_nack;
                    bus.m_data_i = m_rd;
                end
            end
        end
    endtask

    // mode: 0 keep request, 1 drop own at response, 2 drop all at response, 3 drop own right after grant
    task automatic transact(input int mode, input int bound, output int waited, output int start_cycles);
        int k;
        bit ok;
        bit got;
        logic [N-1:0] exp_g;
        k = pick(bus.req_i, ptr_m);
        exp_g = '0;
        exp_g[k] = 1'b1;
        ok = !m_nack && !m_no_busy;
        waited = 0;
        got = 0;
        while (!got && waited < 20) begin
            @(negedge clk);
            waited++;
            got = bus.gnt_o != '0;
        end
        checks++;
        if (bus.gnt_o !== exp_g) begin
            fails++;
            $display("FAIL grant: gnt_o=%b expected %b", bus.gnt_o, exp_g);
        end
        if (mode == 3) bus.req_i[k] = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.m_read_nwrite_o !== r_rnw[k] || bus.m_slave_addr_o !== r_addr[k] || bus.m_data_o !== r_wd[k]) begin
            fails++;
            $display("FAIL latch: rnw/addr/data=%b/%h/%h expected %b/%h/%h", bus.m_read_nwrite_o,
                     bus.m_slave_addr_o, bus.m_data_o, r_rnw[k], r_addr[k], r_wd[k]);
        end
        start_cycles = 0;
        got = 0;
        for (int t = 0; t < bound && !got; t++) begin
            if (bus.m_start_o === 1'b1) start_cycles++;
            got = (bus.done_o | bus.err_o) != '0;
            if (!got) @(negedge clk);
        end
        checks++;
        if (!got) begin
            fails++;
            $display("FAIL response: no done/err within %0d cycles for req %0d", bound, k);
        end else if (bus.done_o !== (ok ? exp_g : '0) || bus.err_o !== (ok ? '0 : exp_g)) begin
            fails++;
            $display("FAIL response: done=%b err=%b expected done=%b err=%b", bus.done_o, bus.err_o,
                     ok ? exp_g : '0, ok ? '0 : exp_g);
        end
        if (ok && r_rnw[k]) begin
            last_rd = m_rd;
            checks++;
            if (bus.rdata_o !== last_rd) begin
                fails++;
                $display("FAIL rdata: rdata_o=%h expected %h", bus.rdata_o, last_rd);
            end
        end
        if (mode == 1) bus.req_i[k] = 1'b0;
        if (mode == 2) bus.req_i = '0;
        ptr_m = (k + 1) % N;
        @(negedge clk);
        checks++;
        if (bus.done_o !== '0 || bus.err_o !== '0 || bus.gnt_o !== '0 || bus.arb_busy_o !== 1'b0 ||
            bus.m_start_o !== 1'b0 || bus.rdata_o !== last_rd) begin
            fails++;
            $display("FAIL idle: done=%b err=%b gnt=%b busy=%b start=%b rdata=%h expected zeros, rdata %h",
                     bus.done_o, bus.err_o, bus.gnt_o, bus.arb_busy_o, bus.m_start_o, bus.rdata_o, last_rd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_i = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.gnt_o, bus.done_o, bus.err_o, bus.m_start_o, bus.m_stop_o, bus.m_read_nwrite_o,
             bus.arb_busy_o, bus.rdata_o, bus.m_slave_addr_o, bus.m_data_o} !== '0) begin
            fails++;
            $display("FAIL reset: gnt=%b done=%b err=%b start=%b stop=%b rnw=%b busy=%b rdata=%h addr=%h data=%h expected 0",
                     bus.gnt_o, bus.done_o, bus.err_o, bus.m_start_o, bus.m_stop_o, bus.m_read_nwrite_o,
                     bus.arb_busy_o, bus.rdata_o, bus.m_slave_addr_o, bus.m_data_o);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.arb_busy_o !== 1'b0 || bus.gnt_o !== '0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b gnt=%b expected 0/0", bus.arb_busy_o, bus.gnt_o);
        end
    endtask

    task automatic test_round_robin();
        int w;
        int s;
        for (int k = 0; k < N; k++) set_req(k, 1'($urandom), 7'($urandom), 8'($urandom));
        m_dly = 1;
        m_len = 4;
        m_nack = 0;
        m_rd = 8'h33;
        bus.req_i = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            transact(t == 4 ? 2 : 0, 200, w, s);
            if (t > 0) begin
                checks++;
                if (w !== 1) begin
                    fails++;
                    $display("FAIL rr_idle_gap: grant after %0d cycles expected 1", w);
                end
            end
        end
    endtask

    task automatic test_write();
        int w;
        int s;
        set_req(2, 1'b0, 7'h50, 8'hA5);
        m_dly = 0;
        m_len = 5;
        m_nack = 0;
        m_rd = 8'hC3;
        bus.req_i = 4'b0100;
        transact(3, 200, w, s);
    endtask

    task automatic test_read();
        int w;
        int s;
        set_req(0, 1'b1, 7'h3C, 8'h00);
        m_dly = 2;
        m_len = 6;
        m_nack = 0;
        m_rd = 8'h5E;
        bus.req_i = 4'b0001;
        transact(1, 200, w, s);
    endtask

    task automatic test_nack();
        int w;
        int s;
        set_req(1, 1'b1, 7'h22, 8'h11);
        m_nack = 1;
        m_rd = 8'hEE;
        bus.req_i = 4'b0010;
        transact(1, 200, w, s);
        m_nack = 0;
    endtask

    task automatic test_start_timeout();
        int w;
        int s;
        for (int k = 0; k < N; k++) set_req(k, 1'($urandom), 7'($urandom), 8'($urandom));
        m_no_busy = 1;
        bus.req_i = 4'b1011;
        transact(1, HOLD + 50, w, s);
        checks++;
        if (s !== HOLD) begin
            fails++;
            $display("FAIL start_hold: m_start_o high %0d cycles expected %0d", s, HOLD);
        end
        m_no_busy = 0;
        m_rd = 8'h6B;
        transact(1, 200, w, s);
        transact(1, 200, w, s);
    endtask

    task automatic test_async_reset();
        int w;
        int s;
        bit saw;
        set_req(2, 1'b1, 7'h0F, 8'h99);
        m_dly = 1;
        m_len = 60;
        bus.req_i = 4'b0100;
        saw = 0;
        for (int t = 0; t < 40 && !(saw && bus.m_start_o === 1'b0); t++) begin
            @(negedge clk);
            saw |= bus.m_start_o;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.arb_busy_o !== 1'b1 || bus.gnt_o !== 4'b0100 || bus.m_start_o !== 1'b0) begin
            fails++;
            $display("FAIL pre_reset: busy=%b gnt=%b start=%b expected 1/0100/0", bus.arb_busy_o, bus.gnt_o, bus.m_start_o);
        end
        rst_n = 1'b0;
        bus.req_i = '0;
        #1;
        checks++;
        if (bus.gnt_o !== '0 || bus.m_start_o !== 1'b0 || bus.arb_busy_o !== 1'b0 || bus.done_o !== '0 || bus.err_o !== '0) begin
            fails++;
            $display("FAIL async_reset: gnt=%b start=%b busy=%b done=%b err=%b expected 0",
                     bus.gnt_o, bus.m_start_o, bus.arb_busy_o, bus.done_o, bus.err_o);
        end
        ptr_m = 0;
        last_rd = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        m_len = 3;
        m_rd = 8'h47;
        set_req(1, 1'b1, 7'h12, 8'h34);
        set_req(3, 1'b0, 7'h56, 8'h78);
        bus.req_i = 4'b1010;
        transact(1, 200, w, s);
        transact(1, 200, w, s);
    endtask

    task automatic test_random();
        int w;
        int s;
        logic [N-1:0] mask;
        for (int r = 0; r < 10; r++) begin
            mask = N'($urandom_range(1, 15));
            for (int k = 0; k < N; k++) if (mask[k]) set_req(k, 1'($urandom), 7'($urandom), 8'($urandom));
            bus.req_i = mask;
            while (bus.req_i != '0) begin
                m_dly = $urandom_range(0, 3);
                m_len = $urandom_range(1, 8);
                m_nack = $urandom_range(0, 3) == 0;
                m_rd = 8'($urandom);
                transact(1, 200, w, s);
            end
        end
        m_nack = 0;
    endtask

`ifdef I2C_ARB_TIMEOUT_EN
    task automatic test_abort();
        int cnt;
        bit got;
        set_req(3, 1'b0, 7'h2A, 8'h5A);
        m_stuck = 1;
        m_nack = 1;
        m_dly = 0;
        bus.req_i = 4'b1000;
        got = 0;
        for (int t = 0; t < 40 && !(got && bus.m_start_o === 1'b0); t++) begin
            @(negedge clk);
            got |= bus.m_start_o;
        end
        cnt = 0;
        while (bus.m_stop_o !== 1'b1 && cnt < TMO + 50) begin
            cnt++;
            @(negedge clk);
        end
        checks++;
        if (cnt !== TMO) begin
            fails++;
            $display("FAIL abort_timeout: m_stop_o rose after %0d cycles expected %0d", cnt, TMO);
        end
        got = 0;
        for (int t = 0; t < TMO + 50 && !got; t++) begin
            got = (bus.done_o | bus.err_o) != '0;
            if (!got) @(negedge clk);
        end
        checks++;
        if (bus.err_o !== 4'b1000 || bus.done_o !== '0) begin
            fails++;
            $display("FAIL abort_err: err=%b done=%b expected 1000/0000", bus.err_o, bus.done_o);
        end
        bus.req_i = '0;
        ptr_m = 0;
        m_stuck = 0;
        m_nack = 0;
        @(negedge clk);
        checks++;
        if (bus.m_stop_o !== 1'b0 || bus.arb_busy_o !== 1'b0) begin
            fails++;
            $display("FAIL abort_idle: stop=%b busy=%b expected 0/0", bus.m_stop_o, bus.arb_busy_o);
        end
    endtask
`endif

    initial begin
        bus.req_i = '0;
        bus.req_rnw_i = '0;
        bus.req_addr_i = '0;
        bus.req_wdata_i = '0;
        bus.m_data_i = '0;
        bus.m_busy_i = 1'b0;
        bus.m_error_i = 1'b0;
        bus.m_success_i = 1'b0;
        for (int k = 0; k < N; k++) set_req(k, 1'b0, '0, '0);
        fork
            master_model();
        join_none
        test_reset();
        test_round_robin();
        test_write();
        test_read();
        test_nack();
        test_start_timeout();
        test_async_reset();
        test_random();
`ifdef I2C_ARB_TIMEOUT_EN
        test_abort();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule
